// File: rtl/apb_ram_pkg.sv
// Shared types and helpers for the banked APB RAM slave.
package apb_ram_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Individual error causes, kept separate so a waveform shows why PSLVERR fired
    typedef struct packed {
        logic misalign;
        logic out_of_range;
        logic strb;
        logic prot;
    } err_t;

    function automatic int lane_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Single-port RAM bank: synchronous read, per-byte write enable, no reset.
module ram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 256,
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ROW_W-1:0]      addr,
    input  logic [STRB_W-1:0]     be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/apb_ram_banked.sv
// APB4 slave with word-interleaved, byte-writable RAM banks, programmable
// wait states and PSLVERR checking for alignment, range, strobe and PPROT.
module apb_ram_banked
    import apb_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int NUM_BANKS  = 4,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 0,
    parameter int REQ_PRIV   = 0,
    parameter int REQ_SECURE = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int LSB    = lane_lsb(DATA_WIDTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ROWS   = DEPTH / NUM_BANKS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q;
    logic [31:0]           word_ext;
    logic [BANK_W-1:0]     bank;
    logic [ROW_W-1:0]      row;
    err_t                  err_set;
    logic                  err_now;
    logic                  setup, complete, rd_en, wr_en;

    // Transfer fields captured on the setup edge
    err_t                  err_p0;
    logic                  write_p0;
    logic [BANK_W-1:0]     bank_p0;
    logic [ROW_W-1:0]      row_p0;
    logic [STRB_W-1:0]     strb_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;

    logic [BANK_W-1:0]     rd_bank_q;
    logic                  rd_zero_q;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  unused_prot;

    assign unused_prot = PPROT[2];

    assign word_ext = 32'(PADDR[ADDR_WIDTH-1:LSB]);
    assign bank     = BANK_W'(word_ext % 32'(NUM_BANKS));
    assign row      = ROW_W'(word_ext / 32'(NUM_BANKS));

    always_comb begin
        err_set              = '0;
        err_set.misalign     = |PADDR[LSB-1:0];
        err_set.out_of_range = (word_ext >= 32'(DEPTH));
        err_set.strb         = !PWRITE && (|PSTRB);
        err_set.prot         = ((REQ_PRIV != 0) && !PPROT[0]) ||
                               ((REQ_SECURE != 0) && PPROT[1]);
    end

    assign err_now  = |err_set;
    assign setup    = (state_q == IDLE) && PSEL && !PENABLE;
    assign PREADY   = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign PSLVERR  = PREADY && (|err_p0);
    assign complete = PREADY && PSEL && PENABLE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (setup) state_d = ACCESS;
            ACCESS: if (!(PSEL && PENABLE) || (cnt_q == 4'd0)) state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            err_p0    <= '0;
            rd_zero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (setup) begin
                cnt_q  <= err_now ? 4'd0 : (PWRITE ? 4'(WR_WAIT) : 4'(RD_WAIT));
                err_p0 <= err_set;
                // Error reads return zero; writes leave the read data untouched
                if (!PWRITE) begin
                    rd_zero_q <= err_now;
                end
            end else if ((state_q == ACCESS) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (setup) begin
            write_p0 <= PWRITE;
            bank_p0  <= bank;
            row_p0   <= row;
            strb_p0  <= PSTRB;
            wdata_p0 <= PWDATA;
            if (!PWRITE) begin
                rd_bank_q <= bank;
            end
        end
    end

    // Reads launch on the setup edge, writes on the completion edge; the two never coincide
    assign rd_en = setup && !PWRITE && !err_now && !PRESET;
    assign wr_en = complete && write_p0 && !(|err_p0) && !PRESET;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROWS       (ROWS)
        ) u_bank (
            .clk   (PCLK),
            .en    ((rd_en && (bank == BANK_W'(g))) || (wr_en && (bank_p0 == BANK_W'(g)))),
            .we    (wr_en),
            .addr  ((state_q == ACCESS) ? row_p0 : row),
            .be    (strb_p0),
            .wdata (wdata_p0),
            .rdata (bank_rdata[g])
        );
    end

    assign PRDATA = rd_zero_q ? '0 : bank_rdata[rd_bank_q];

endmodule

// File: tb/tb_apb_ram_banked.sv
// Directed bench: a default instance and a privileged, slow-write instance.
module tb_apb_ram_banked;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel1, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 pclk = ~pclk;

    apb_ram_banked u_dut (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_ram_banked #(.WR_WAIT(3), .REQ_PRIV(1)) u_prv (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    typedef struct {
        bit          sel;
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  p;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_waits;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pstrb = 4'h0;
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    // One complete transfer; leaves the bus right after the completion edge
    task automatic xfer(input bit sel, input logic w, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic er, output int waits);
        psel0 = !sel; psel1 = sel; penable = 1'b0;
        pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = p;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        while (!(sel ? pready1 : pready0) && waits < 40) begin
            waits++;
            @(posedge pclk); #1;
        end
        rd = sel ? prdata1 : prdata0;
        er = sel ? pslverr1 : pslverr0;
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          waits;

        vecs.push_back('{0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0,        1'b0, 0, "wr_10"});
        vecs.push_back('{0, 1'b0, 16'h0010, 32'h0,        4'h0, 3'b000, 1, 32'hDEADBEEF, 1'b0, 1, "rd_10"});
        vecs.push_back('{0, 1'b1, 16'h0000, 32'hA0A0A0A0, 4'hF, 3'b000, 0, 32'h0,        1'b0, 0, "wr_00"});
        vecs.push_back('{0, 1'b1, 16'h0008, 32'hC0C0C0C0, 4'hF, 3'b000, 0, 32'h0,        1'b0, 0, "wr_08"});
        vecs.push_back('{0, 1'b1, 16'h0004, 32'h11223344, 4'hF, 3'b000, 0, 32'h0,        1'b0, 0, "wr_04"});
        vecs.push_back('{0, 1'b1, 16'h0004, 32'hAABBCCDD, 4'h5, 3'b000, 0, 32'h0,        1'b0, 0, "wr_04_strb"});
        vecs.push_back('{0, 1'b0, 16'h0004, 32'h0,        4'h0, 3'b000, 1, 32'h11BB33DD, 1'b0, 1, "rd_04"});
        vecs.push_back('{0, 1'b0, 16'h0000, 32'h0,        4'h0, 3'b000, 1, 32'hA0A0A0A0, 1'b0, 1, "rd_00"});
        vecs.push_back('{0, 1'b0, 16'h0008, 32'h0,        4'h0, 3'b000, 1, 32'hC0C0C0C0, 1'b0, 1, "rd_08"});
        vecs.push_back('{0, 1'b0, 16'h0002, 32'h0,        4'h0, 3'b000, 1, 32'h0,        1'b1, 0, "rd_misalign"});
        vecs.push_back('{0, 1'b1, 16'h1000, 32'h55555555, 4'hF, 3'b000, 0, 32'h0,        1'b1, 0, "wr_oor"});
        vecs.push_back('{0, 1'b0, 16'h0000, 32'h0,        4'h0, 3'b000, 1, 32'hA0A0A0A0, 1'b0, 1, "rd_00_alias"});
        vecs.push_back('{0, 1'b0, 16'h0010, 32'h0,        4'h1, 3'b000, 1, 32'h0,        1'b1, 0, "rd_strb"});
        vecs.push_back('{0, 1'b1, 16'h0000, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 32'h0,        1'b0, 0, "wr_strb0"});
        vecs.push_back('{0, 1'b0, 16'h0000, 32'h0,        4'h0, 3'b000, 1, 32'hA0A0A0A0, 1'b0, 1, "rd_00_keep"});
        vecs.push_back('{0, 1'b1, 16'h0FFC, 32'h12345678, 4'hF, 3'b000, 0, 32'h0,        1'b0, 0, "wr_last"});
        vecs.push_back('{0, 1'b0, 16'h0FFC, 32'h0,        4'h0, 3'b000, 1, 32'h12345678, 1'b0, 1, "rd_last"});
        vecs.push_back('{1, 1'b1, 16'h0020, 32'h0BADF00D, 4'hF, 3'b001, 0, 32'h0,        1'b0, 3, "wr_priv"});
        vecs.push_back('{1, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 32'h0,        1'b1, 0, "wr_unpriv"});
        vecs.push_back('{1, 1'b0, 16'h0020, 32'h0,        4'h0, 3'b001, 1, 32'h0BADF00D, 1'b0, 1, "rd_priv"});
        vecs.push_back('{1, 1'b0, 16'h0020, 32'h0,        4'h0, 3'b000, 1, 32'h0,        1'b1, 0, "rd_unpriv"});

        preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 16'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
        @(posedge pclk); #1;
        for (int i = 0; i < 2; i++) begin
            psel0 = ~psel0; psel1 = ~psel1;
            check("rst_pready", {31'h0, pready0}, 32'h0);
            check("rst_pslverr", {31'h0, pslverr0}, 32'h0);
            check("rst_prdata", prdata0, 32'h0);
            check("rst_pready_prv", {31'h0, pready1}, 32'h0);
            @(posedge pclk); #1;
        end
        preset = 1'b0;
        idle(1);

        foreach (vecs[i]) begin
            xfer(vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].p, rd, er, waits);
            check({vecs[i].name, "_err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
            check({vecs[i].name, "_waits"}, waits, vecs[i].exp_waits);
            if (vecs[i].chk_rd) check({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
            idle(1);
        end

        // Back-to-back: write, read, write with no idle cycles in between
        xfer(0, 1'b1, 16'h0030, 32'h01010101, 4'hF, 3'b000, rd, er, waits);
        check("b2b_wr1_waits", waits, 0);
        xfer(0, 1'b0, 16'h0030, 32'h0, 4'h0, 3'b000, rd, er, waits);
        check("b2b_rd_waits", waits, 1);
        check("b2b_rd_data", rd, 32'h01010101);
        xfer(0, 1'b1, 16'h0034, 32'h02020202, 4'hF, 3'b000, rd, er, waits);
        check("b2b_wr2_waits", waits, 0);
        check("b2b_wr2_err", {31'h0, er}, 32'h0);
        idle(1);
        check("hold_prdata", prdata0, 32'h01010101);
        check("idle_pready", {31'h0, pready0}, 32'h0);
        check("idle_pslverr", {31'h0, pslverr0}, 32'h0);
        xfer(0, 1'b0, 16'h0034, 32'h0, 4'h0, 3'b000, rd, er, waits);
        check("b2b_rd2_data", rd, 32'h02020202);
        idle(1);

        // Abort a slow write on the WR_WAIT=3 instance by dropping PENABLE
        xfer(1, 1'b1, 16'h0040, 32'h77777777, 4'hF, 3'b001, rd, er, waits);
        check("abort_pre_waits", waits, 3);
        idle(1);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0040;
        pwdata = 32'h99999999; pstrb = 4'hF; pprot = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("abort_wait_pready", {31'h0, pready1}, 32'h0);
        penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_pready", {31'h0, pready1}, 32'h0);
        psel1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            check("abort_idle_pready", {31'h0, pready1}, 32'h0);
        end
        xfer(1, 1'b0, 16'h0040, 32'h0, 4'h0, 3'b001, rd, er, waits);
        check("abort_rd_data", rd, 32'h77777777);
        idle(1);

        // Reset during a read wait cycle
        xfer(0, 1'b1, 16'h0050, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, waits);
        idle(1);
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0050; pstrb = 4'h0;
        @(posedge pclk); #1;
        penable = 1'b1;
        preset  = 1'b1;
        @(posedge pclk); #1;
        check("rstmid_pready", {31'h0, pready0}, 32'h0);
        check("rstmid_prdata", prdata0, 32'h0);
        preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            check("rstmid_idle_pready", {31'h0, pready0}, 32'h0);
        end
        xfer(0, 1'b0, 16'h0050, 32'h0, 4'h0, 3'b000, rd, er, waits);
        check("rstmid_rd_data", rd, 32'hCAFEF00D);
        check("rstmid_rd_err", {31'h0, er}, 32'h0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_ram_banked.md
Name: apb_ram_banked

Overview:
- Next-generation APB4 slave memory: APB slave FSM plus banked, byte-writable RAM in one block.
- Adds over the previous wrapper:
  - parametrised data width, depth and bank count;
  - programmable read/write wait states;
  - address-range, alignment, strobe and PPROT error checking (PSLVERR).
- Sits behind the APB decoder as a leaf peripheral; one instance per memory-mapped RAM region.

Parameters:
- ADDR_WIDTH, 16, PADDR width (byte address)
- DATA_WIDTH, 32, PRDATA/PWDATA width; must be 32 or 64
- DEPTH, 1024, total words; power of two
- NUM_BANKS, 4, word-interleaved banks; power of two, divides DEPTH
- RD_WAIT, 1, extra access-phase cycles on reads (0..15)
- WR_WAIT, 0, extra access-phase cycles on writes (0..15)
- REQ_PRIV, 0, if 1 then PPROT[0]=0 is an error
- REQ_SECURE, 0, if 1 then PPROT[1]=1 (non-secure) is an error

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte lane enables
- PPROT  in  3  protection attributes
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error, valid only while PREADY=1

Behaviour:
- Reset:
  - One clock, PCLK; PRESET is synchronous and active-high.
  - PRESET=1 at a PCLK edge: FSM to IDLE, PRDATA=0, PREADY=0, PSLVERR=0, wait counter=0.
  - RAM contents are not cleared.
- Address decode:
  - LSB = log2(DATA_WIDTH/8).
  - word = PADDR[ADDR_WIDTH-1:LSB]; bank = word mod NUM_BANKS; row = word / NUM_BANKS.
- Error conditions, evaluated in the setup cycle, OR'd:
  - PADDR[LSB-1:0] != 0 (misaligned);
  - word >= DEPTH (out of range);
  - read with PSTRB != 0;
  - PPROT violation per REQ_PRIV / REQ_SECURE.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Waits for a setup cycle, PSEL=1 & PENABLE=0.
  - On the setup edge it latches addr/write/strb/wdata/err.
  - Loads cnt = err ? 0 : (PWRITE ? WR_WAIT : RD_WAIT).
  - For a non-error read, loads PRDATA <= bank[row] on the same edge.
  - Goes to ACCESS.
- ACCESS:
  - PREADY = (cnt==0), registered-state derived, with no combinational path from PSEL/PENABLE.
  - PSLVERR = PREADY & err.
  - cnt decrements each cycle while nonzero.
- Completion edge (PREADY=1 & PSEL=1 & PENABLE=1):
  - Non-error write: each byte i of the target bank updates iff PSTRB[i]; other banks are untouched.
  - Error write: no RAM update.
  - Error read: PRDATA=0.
  - Next state IDLE.
- Latency: a setup cycle followed by 1+RD_WAIT access cycles for reads, 1+WR_WAIT for writes, and 1 for errors.
- Back-to-back transfers: a new setup cycle is accepted in the cycle immediately after completion. There are no dead cycles.
- Write with PSTRB=0: OKAY response, no RAM change.
- Protocol abort: PSEL=0 or PENABLE=0 while in ACCESS returns the FSM to IDLE with no RAM write and PREADY=0.
- Outside ACCESS: PREADY=0, PSLVERR=0, PRDATA holds its last value.
- PRESET mid-transfer: any pending write is dropped and the response is never issued.

Decomposition:
- Package apb_ram_pkg:
  - state_t enum {IDLE, ACCESS};
  - function clog2-based LSB computation;
  - err_t struct {misalign, range, strb, prot}, used for debug visibility.
- Sub-module ram_bank #(DATA_WIDTH, ROWS): single-port, synchronous read, per-byte write enable, no reset.
  - Instantiated NUM_BANKS times via generate.
  - The top holds the FSM, decode and read-data mux.

Test Plan (defaults, 32-bit data):
- Reset check: PRESET=1 for 2 cycles with PSEL toggling -> PREADY=0, PSLVERR=0, PRDATA=0 throughout.
- Basic write/read:
  - write 0xDEADBEEF to 0x0010, PSTRB=4'hF -> PREADY in the first access cycle;
  - read 0x0010 -> PREADY after 1 wait cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes and banking:
  - write 0x11223344 to 0x0004, then 0xAABBCCDD with PSTRB=4'b0101 -> read returns 0x11BB33DD;
  - 0x0000 and 0x0008 are unchanged (other banks).
- Errors:
  - read 0x0002 (misaligned) -> PSLVERR=1, PRDATA=0, zero waits;
  - write 0x1000 (word 1024 >= DEPTH) -> PSLVERR=1 and no RAM aliasing at word 0;
  - with REQ_PRIV=1, PPROT=3'b000 -> PSLVERR=1.
- Back-to-back and abort:
  - write, read, write to consecutive addresses with no idle cycles -> all complete with correct data;
  - deassert PENABLE mid-wait (WR_WAIT=3) -> no write, FSM returns to IDLE.
- Reset mid-op: assert PRESET during a read wait cycle -> PREADY never asserts, and a subsequent read returns the pre-reset RAM contents.
